// File: rtl/fetch_controller.sv
// Fetch-stage sequencing and redirect arbitration.
// Runs the post-reset boot sequence and picks one redirect per cycle
// (trap > mret > branch > replay). After each PC discontinuity it squashes
// wrong-path instructions by dropping decode_valid. Also holds the exception
// PC and a count of accepted redirects.
module fetch_controller #(
  parameter int unsigned BOOT_CYCLES = 2,
  parameter int unsigned FLUSH_DEPTH = 1,
  parameter logic [63:0] TRAP_VECTOR = 64'd1024
) (
  input  logic        clock,
  input  logic        reset_n,
  input  logic        trap_request,
  input  logic [63:0] trap_pc,
  input  logic        mret_request,
  input  logic        ex_branch_taken,
  input  logic [63:0] ex_branch_target,
  input  logic        replay_request,
  input  logic [63:0] replay_pc,
  output logic        fetch_reset_pc,
  output logic        fetch_branch,
  output logic [63:0] fetch_pc_target,
  output logic        decode_valid,
  output logic [63:0] epc,
  output logic [31:0] redirect_count,
  output logic [1:0]  state
);

  typedef enum logic [1:0] {
    StBoot  = 2'd0,
    StFlush = 2'd1,
    StRun   = 2'd2
  } state_e;

  state_e      state_q;
  logic [31:0] boot_cnt_q;
  logic [31:0] flush_cnt_q;
  logic [63:0] epc_q;
  logic [31:0] redirect_count_q;

  logic        redirect;
  logic        take_trap;
  logic [63:0] redirect_target;

  // Priority arbitration; requests are ignored while the fetch stage is held in reset.
  always_comb begin
    redirect        = 1'b0;
    take_trap       = 1'b0;
    redirect_target = 64'd0;
    if (state_q != StBoot) begin
      if (trap_request) begin
        redirect        = 1'b1;
        take_trap       = 1'b1;
        redirect_target = TRAP_VECTOR;
      end else if (mret_request) begin
        redirect        = 1'b1;
        redirect_target = epc_q;  // pre-update value
      end else if (ex_branch_taken) begin
        redirect        = 1'b1;
        redirect_target = ex_branch_target;
      end else if (replay_request) begin
        redirect        = 1'b1;
        redirect_target = replay_pc;
      end
    end
  end

  // Boot/flush/run sequencing plus epc and redirect counter.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q          <= StBoot;
      boot_cnt_q       <= 32'd0;
      flush_cnt_q      <= 32'd0;
      epc_q            <= 64'd0;
      redirect_count_q <= 32'd0;
    end else begin
      if (redirect) begin
        redirect_count_q <= redirect_count_q + 32'd1;
      end
      if (take_trap) begin
        epc_q <= trap_pc;
      end
      unique case (state_q)
        StBoot: begin
          if (boot_cnt_q == 32'(BOOT_CYCLES - 1)) begin
            state_q     <= StFlush;
            flush_cnt_q <= 32'(FLUSH_DEPTH);
          end else begin
            boot_cnt_q <= boot_cnt_q + 32'd1;
          end
        end
        StFlush: begin
          if (redirect) begin
            flush_cnt_q <= 32'(FLUSH_DEPTH);
          end else if (flush_cnt_q <= 32'd1) begin
            state_q     <= StRun;
            flush_cnt_q <= 32'd0;
          end else begin
            flush_cnt_q <= flush_cnt_q - 32'd1;
          end
        end
        StRun: begin
          if (redirect) begin
            state_q     <= StFlush;
            flush_cnt_q <= 32'(FLUSH_DEPTH);
          end
        end
        default: state_q <= StBoot;
      endcase
    end
  end

  // Output drive: fetch_reset_pc decodes straight from the state register.
  always_comb begin
    fetch_reset_pc  = (state_q == StBoot);
    fetch_branch    = redirect;
    fetch_pc_target = redirect_target;
    decode_valid    = (state_q == StRun) && !redirect;
    epc             = epc_q;
    redirect_count  = redirect_count_q;
    state           = state_q;
  end

endmodule

// File: tb/tb_fetch_controller.sv
// Scoreboard bench for fetch_controller: two instances (short and deep flush)
// share one randomized stimulus stream; a reference model predicts each
// cycle's outputs and a separate monitor compares them.
module tb_fetch_controller;

  localparam logic [63:0] TV = 64'd1024;

  logic        clock;
  logic        reset_n;
  logic        trap_request;
  logic [63:0] trap_pc;
  logic        mret_request;
  logic        ex_branch_taken;
  logic [63:0] ex_branch_target;
  logic        replay_request;
  logic [63:0] replay_pc;

  logic        rpc0, br0, dv0, rpc1, br1, dv1;
  logic [63:0] tgt0, epc0, tgt1, epc1;
  logic [31:0] cnt0, cnt1;
  logic [1:0]  st0, st1;

  int checks   = 0;
  int failures = 0;

  typedef struct {
    logic [1:0]  st;
    logic        rpc;
    logic        br;
    logic [63:0] tgt;
    logic        dv;
    logic [63:0] epc;
    logic [31:0] cnt;
  } exp_t;

  typedef struct {
    int          boot_left;   // cycles of fetch reset still to come
    int          squash_left; // further cycles decode stays invalid
    logic [63:0] epc;
    logic [31:0] cnt;
  } mdl_t;

  exp_t q0[$];
  exp_t q1[$];
  mdl_t m[2];
  int   bc[2] = '{2, 3};
  int   fd[2] = '{1, 3};

  fetch_controller #(.BOOT_CYCLES(2), .FLUSH_DEPTH(1), .TRAP_VECTOR(TV)) dut0 (
    .clock(clock), .reset_n(reset_n), .trap_request(trap_request), .trap_pc(trap_pc),
    .mret_request(mret_request), .ex_branch_taken(ex_branch_taken),
    .ex_branch_target(ex_branch_target), .replay_request(replay_request),
    .replay_pc(replay_pc), .fetch_reset_pc(rpc0), .fetch_branch(br0),
    .fetch_pc_target(tgt0), .decode_valid(dv0), .epc(epc0), .redirect_count(cnt0),
    .state(st0)
  );

  fetch_controller #(.BOOT_CYCLES(3), .FLUSH_DEPTH(3), .TRAP_VECTOR(TV)) dut1 (
    .clock(clock), .reset_n(reset_n), .trap_request(trap_request), .trap_pc(trap_pc),
    .mret_request(mret_request), .ex_branch_taken(ex_branch_taken),
    .ex_branch_target(ex_branch_target), .replay_request(replay_request),
    .replay_pc(replay_pc), .fetch_reset_pc(rpc1), .fetch_branch(br1),
    .fetch_pc_target(tgt1), .decode_valid(dv1), .epc(epc1), .redirect_count(cnt1),
    .state(st1)
  );

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  task automatic chk_exp(input int id, input exp_t e, input logic [1:0] st, input logic rpc,
                         input logic br, input logic [63:0] tgt, input logic dv,
                         input logic [63:0] ep, input logic [31:0] cnt);
    chk($sformatf("dut%0d.state", id), 64'(st), 64'(e.st));
    chk($sformatf("dut%0d.fetch_reset_pc", id), 64'(rpc), 64'(e.rpc));
    chk($sformatf("dut%0d.fetch_branch", id), 64'(br), 64'(e.br));
    chk($sformatf("dut%0d.fetch_pc_target", id), tgt, e.tgt);
    chk($sformatf("dut%0d.decode_valid", id), 64'(dv), 64'(e.dv));
    chk($sformatf("dut%0d.epc", id), ep, e.epc);
    chk($sformatf("dut%0d.redirect_count", id), 64'(cnt), 64'(e.cnt));
  endtask

  // Monitor: compare each presented cycle against the oldest prediction.
  initial begin
    exp_t e;
    forever begin
      @(negedge clock);
      #2;
      if (q0.size() > 0) begin
        e = q0.pop_front();
        chk_exp(0, e, st0, rpc0, br0, tgt0, dv0, epc0, cnt0);
      end
      if (q1.size() > 0) begin
        e = q1.pop_front();
        chk_exp(1, e, st1, rpc1, br1, tgt1, dv1, epc1, cnt1);
      end
    end
  end

  // Drive one cycle of inputs, predict the outputs of both instances, advance the model.
  task automatic drive(input logic rn, input logic tr, input logic [63:0] tpc, input logic mr,
                       input logic br, input logic [63:0] bt, input logic rp,
                       input logic [63:0] rpcv);
    @(negedge clock);
    reset_n          = rn;
    trap_request     = tr;
    trap_pc          = tpc;
    mret_request     = mr;
    ex_branch_taken  = br;
    ex_branch_target = bt;
    replay_request   = rp;
    replay_pc        = rpcv;
    for (int i = 0; i < 2; i++) begin
      exp_t e;
      logic boot, acc;
      if (!rn) begin
        m[i] = '{boot_left: bc[i], squash_left: 0, epc: 64'd0, cnt: 32'd0};
        e    = '{st: 2'd0, rpc: 1'b1, br: 1'b0, tgt: 64'd0, dv: 1'b0, epc: 64'd0, cnt: 32'd0};
      end else begin
        boot  = m[i].boot_left > 0;
        acc   = !boot && (tr || mr || br || rp);
        e.rpc = boot;
        e.st  = boot ? 2'd0 : (m[i].squash_left > 0 ? 2'd1 : 2'd2);
        e.br  = acc;
        e.tgt = !acc ? 64'd0 : tr ? TV : mr ? m[i].epc : br ? bt : rpcv;
        e.dv  = !boot && m[i].squash_left == 0 && !acc;
        e.epc = m[i].epc;
        e.cnt = m[i].cnt;
        if (boot) begin
          m[i].boot_left--;
          if (m[i].boot_left == 0) m[i].squash_left = fd[i];
        end else if (acc) begin
          m[i].squash_left = fd[i];
          m[i].cnt         = m[i].cnt + 32'd1;
          if (tr) m[i].epc = tpc;
        end else if (m[i].squash_left > 0) begin
          m[i].squash_left--;
        end
      end
      if (i == 0) q0.push_back(e);
      else        q1.push_back(e);
    end
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) drive(1'b1, 0, 64'd0, 0, 0, 64'd0, 0, 64'd0);
  endtask

  task automatic random_cycles(input int n);
    for (int k = 0; k < n; k++) begin
      drive(1'b1, $urandom_range(0, 9) == 0, {$urandom, $urandom},
            $urandom_range(0, 7) == 0, $urandom_range(0, 5) == 0, {$urandom, $urandom},
            $urandom_range(0, 5) == 0, {$urandom, $urandom});
    end
  endtask

  initial begin
    reset_n = 1'b0; trap_request = 1'b0; trap_pc = '0; mret_request = 1'b0;
    ex_branch_taken = 1'b0; ex_branch_target = '0; replay_request = 1'b0; replay_pc = '0;
    for (int i = 0; i < 2; i++) m[i] = '{boot_left: bc[i], squash_left: 0, epc: 0, cnt: 0};

    // Reset, then boot with a branch held during the first boot cycles (masked).
    for (int k = 0; k < 3; k++) drive(1'b0, 0, 64'd0, 0, 0, 64'd0, 0, 64'd0);
    drive(1'b1, 0, 64'd0, 0, 1, 64'd99, 0, 64'd0);
    drive(1'b1, 0, 64'd0, 0, 1, 64'd99, 0, 64'd0);
    idle(6);

    // Branch to 40 in RUN.
    drive(1'b1, 0, 64'd0, 0, 1, 64'd40, 0, 64'd0);
    idle(5);

    // All four together: trap wins; following mret uses the new epc.
    drive(1'b1, 1, 64'd7, 1, 1, 64'd50, 1, 64'd60);
    drive(1'b1, 0, 64'd0, 1, 0, 64'd0, 0, 64'd0);
    idle(5);

    // Branch, then a replay to 12 two cycles later (mid-flush on the deep instance).
    drive(1'b1, 0, 64'd0, 0, 1, 64'd80, 0, 64'd0);
    idle(1);
    drive(1'b1, 0, 64'd0, 0, 0, 64'd0, 1, 64'd12);
    idle(6);

    random_cycles(400);
    idle(6);

    // Counter wrap on both instances.
    @(negedge clock);
    #3;
    force dut0.redirect_count_q = 32'hFFFF_FFFF;
    force dut1.redirect_count_q = 32'hFFFF_FFFF;
    #1;
    release dut0.redirect_count_q;
    release dut1.redirect_count_q;
    m[0].cnt = 32'hFFFF_FFFF;
    m[1].cnt = 32'hFFFF_FFFF;
    drive(1'b1, 0, 64'd0, 0, 0, 64'd0, 1, 64'd5);
    idle(6);

    // Asynchronous reset away from any clock edge.
    @(negedge clock);
    #3;
    reset_n = 1'b0;
    #1;
    chk("async.state0", 64'(st0), 64'd0);
    chk("async.state1", 64'(st1), 64'd0);
    chk("async.reset_pc0", 64'(rpc0), 64'd1);
    chk("async.decode_valid0", 64'(dv0), 64'd0);
    chk("async.epc0", epc0, 64'd0);
    chk("async.epc1", epc1, 64'd0);
    chk("async.count0", 64'(cnt0), 64'd0);
    chk("async.count1", 64'(cnt1), 64'd0);
    drive(1'b0, 0, 64'd0, 0, 1, 64'd3, 0, 64'd0);
    drive(1'b0, 0, 64'd0, 0, 0, 64'd0, 0, 64'd0);
    idle(2);
    random_cycles(200);
    idle(8);

    @(negedge clock);
    #4;
    chk("queue0.drained", 64'(q0.size()), 64'd0);
    chk("queue1.drained", 64'(q1.size()), 64'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/fetch_controller.md
# fetch_controller

Sequencing and redirect-arbitration controller for the fetch stage. It owns the fetch stage's `reset_pc`, `branch` and `pc_target` inputs, and it runs the post-reset boot sequence. Each cycle it arbitrates between four redirect sources (trap, trap return, taken branch, replay), and after every PC discontinuity it squashes wrong-path instructions through a valid qualifier to decode. It also holds the exception PC (epc) register and a redirect performance counter.

## Interface

Parameters:
- `BOOT_CYCLES`, default 2: cycles `fetch_reset_pc` stays high after reset release. Must be ≥1.
- `FLUSH_DEPTH`, default 1: cycles decode is invalidated after a redirect or boot. Must be ≥1; 1 is the fetch stage's inherent wrong-path depth.
- `TRAP_VECTOR`, default 64'd1024: fetch target on a trap. This is a word address, like the fetch PC.

Ports:
- `clock`, in, 1: single clock, rising edge.
- `reset_n`, in, 1: asynchronous, active-low reset.
- `trap_request`, in, 1: exception raised. Highest priority.
- `trap_pc`, in, 64: PC of the faulting instruction. Captured into epc on an accepted trap.
- `mret_request`, in, 1: trap return. The fetch target is the current epc.
- `ex_branch_taken`, in, 1: a taken branch or jump resolved in execute.
- `ex_branch_target`, in, 64: target of that branch.
- `replay_request`, in, 1: hazard unit asks to refetch from `replay_pc`. Lowest priority.
- `replay_pc`, in, 64: replay target.
- `fetch_reset_pc`, out, 1: drives the fetch stage's `reset_pc`.
- `fetch_branch`, out, 1: drives the fetch stage's `branch`.
- `fetch_pc_target`, out, 64: drives the fetch stage's `pc_target`.
- `decode_valid`, out, 1: qualifies the current fetch output to decode.
- `epc`, out, 64: saved exception PC.
- `redirect_count`, out, 32: count of accepted redirects. Wraps modulo 2^32.
- `state`, out, 2: current FSM state. BOOT=0, FLUSH=1, RUN=2.

## Operation

FSM states:
- **BOOT**
  - `fetch_reset_pc`=1; all redirect requests are ignored.
  - A counter counts BOOT_CYCLES cycles, then the FSM moves to FLUSH with the flush counter loaded to FLUSH_DEPTH.
- **FLUSH**
  - `decode_valid`=0.
  - The flush counter decrements each cycle. When it reaches 1 and no redirect is accepted, the FSM moves to RUN.
  - An accepted redirect reloads the counter to FLUSH_DEPTH and the FSM stays in FLUSH.
- **RUN**
  - `decode_valid`=1 unless a redirect is accepted this cycle.
  - An accepted redirect moves the FSM to FLUSH with the counter loaded to FLUSH_DEPTH.

Redirect arbitration is combinational and evaluated only in FLUSH and RUN:
- The priority order is trap > mret > branch > replay.
- A redirect is accepted if any request is high.
- While a redirect is accepted, `fetch_branch`=1 and `fetch_pc_target` is set as follows:
  - trap: TRAP_VECTOR.
  - mret: the epc register value before any update.
  - branch: `ex_branch_target`.
  - replay: `replay_pc`.
- When no redirect is accepted, `fetch_branch`=0 and `fetch_pc_target`=0.
- An accepted redirect forces `decode_valid`=0 in that same cycle, which kills the instruction currently at decode.

Register updates:
- epc loads `trap_pc` only when a trap is accepted.
- `redirect_count` increments by 1 per accepted redirect, regardless of source.
- Requests that lose arbitration are dropped, not queued. The requester must re-assert.
- A request that is held high is accepted again every cycle, and the FSM stays in FLUSH.

## Timing

Reset values (asynchronous, while `reset_n`=0):
- `state`=BOOT, with the boot and flush counters at 0.
- `fetch_reset_pc`=1, `fetch_branch`=0, `fetch_pc_target`=0.
- `decode_valid`=0, `epc`=0, `redirect_count`=0.

Boot timing:
- `reset_n` rises before edge E1. `fetch_reset_pc` is high for edges E1..E_BOOT_CYCLES.
- The FSM is then in FLUSH for FLUSH_DEPTH cycles, then in RUN.
- The first cycle with `decode_valid`=1 shows the instruction at PC 0 with `pc_current_instruction`=0.

Redirect timing:
- Redirect latency is 0 cycles to fetch: a request in cycle N changes the fetch PC at the edge ending cycle N.
- Decode is invalid in cycle N and in the FLUSH_DEPTH cycles that follow.
- The first valid instruction is at the target PC, in cycle N+1+FLUSH_DEPTH.

Other boundary behaviour:
- Reset asserted mid-FLUSH or mid-RUN: the FSM returns to BOOT immediately and epc is cleared.
- Trap and mret in the same cycle: the trap wins, and epc is updated to `trap_pc` at that edge.
- A back-to-back mret sees the new epc one cycle after the trap.
- `redirect_count` at 32'hFFFF_FFFF plus one redirect gives 0.

## Test plan

- **Reset and boot:** hold `reset_n`=0, then release with BOOT_CYCLES=2 and FLUSH_DEPTH=1.
  - `fetch_reset_pc` must be 1 for 2 edges.
  - `decode_valid` must be 0 for 1 further cycle, then 1 with PC 0.
  - `state` must step 0, 0, 1, 2.
- **Branch redirect:** in RUN, pulse `ex_branch_taken` for one cycle with target 64'd40.
  - `fetch_branch`=1 and `fetch_pc_target`=40 in that cycle.
  - `decode_valid` low for 2 cycles, then valid with PC 40.
  - `redirect_count`=1.
- **Priority:** assert trap (`trap_pc`=7), mret, branch and replay together.
  - Target must be 1024 and epc must become 7.
  - With only mret asserted next cycle, the target must be 7.
- **Redirect during FLUSH:** set FLUSH_DEPTH=3 and issue a branch; two cycles later issue a replay to 64'd12.
  - The FSM stays in FLUSH for 3 more cycles.
  - The first valid instruction is at PC 12.
  - `redirect_count`=2.
- **Boot masking and asynchronous reset:** assert `ex_branch_taken` during BOOT; `fetch_branch` must stay 0.
  - Drop `reset_n` mid-RUN with no clock edge.
  - All outputs must reach their reset values immediately.
- **Counter wrap:** preload `redirect_count` to 32'hFFFF_FFFF via force, then issue one redirect; the count must read 0.
